// File: rtl/stopwatch_bcd.sv
// Stopwatch control FSM and MM:SS.t BCD time-keeping.
// Drives the timebase enable and selects live or lap-frozen digits.
module stopwatch_bcd #(
  parameter int MIN_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100ms,
  input  logic       start_stop,
  input  logic       lap_reset,
  output logic       timer_enable,
  output logic       running,
  output logic       lap_active,
  output logic [3:0] disp_tenths,
  output logic [3:0] disp_sec_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_min_ones,
  output logic [3:0] disp_min_tens,
  output logic       wrap_pulse
);

  localparam logic [3:0] MT = 4'(MIN_TENS_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED,
    LAP
  } state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    logic [3:0] t;
  } bcd_t;

  state_t state_q, state_d;
  bcd_t   cnt_q, cnt_d;
  bcd_t   lap_q, lap_d;
  bcd_t   disp_q, disp_d;
  bcd_t   inc;
  logic   run_q, run_d;
  logic   lapa_q, lapa_d;
  logic   wrap_q, wrap_d;
  logic   count_en;
  logic   at_max;

  always_comb begin
    inc = cnt_q;
    if (cnt_q.t != 4'd9) begin
      inc.t = cnt_q.t + 4'd1;
    end else begin
      inc.t = 4'd0;
      if (cnt_q.so != 4'd9) begin
        inc.so = cnt_q.so + 4'd1;
      end else begin
        inc.so = 4'd0;
        if (cnt_q.st != 4'd5) begin
          inc.st = cnt_q.st + 4'd1;
        end else begin
          inc.st = 4'd0;
          if (cnt_q.mo != 4'd9) begin
            inc.mo = cnt_q.mo + 4'd1;
          end else begin
            inc.mo = 4'd0;
            inc.mt = (cnt_q.mt != MT) ? cnt_q.mt + 4'd1 : 4'd0;
          end
        end
      end
    end
  end

  assign at_max = (cnt_q.mt == MT) && (cnt_q.mo == 4'd9) &&
                  (cnt_q.st == 4'd5) && (cnt_q.so == 4'd9) &&
                  (cnt_q.t == 4'd9);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lap_d    = lap_q;
    count_en = tick_100ms &&
               (state_q == RUNNING || state_q == LAP);
    if (count_en) cnt_d = inc;
    // start_stop takes priority over lap_reset in every state
    unique case (state_q)
      IDLE: begin
        if (start_stop) state_d = RUNNING;
      end
      RUNNING: begin
        if (start_stop) begin
          state_d = PAUSED;
        end else if (lap_reset) begin
          state_d = LAP;
          lap_d   = cnt_q;
        end
      end
      LAP: begin
        if (start_stop) begin
          state_d = PAUSED;
          lap_d   = '0;
        end else if (lap_reset) begin
          state_d = RUNNING;
        end
      end
      PAUSED: begin
        if (start_stop) begin
          state_d = RUNNING;
        end else if (lap_reset) begin
          state_d = IDLE;
          cnt_d   = '0;
          lap_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d  = (state_d == RUNNING) || (state_d == LAP);
    lapa_d = (state_d == LAP);
    disp_d = lapa_d ? lap_d : cnt_d;
    wrap_d = count_en && at_max;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lap_q   <= '0;
      disp_q  <= '0;
      run_q   <= 1'b0;
      lapa_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      disp_q  <= disp_d;
      run_q   <= run_d;
      lapa_q  <= lapa_d;
      wrap_q  <= wrap_d;
    end
  end

  assign timer_enable  = run_q;
  assign running       = run_q;
  assign lap_active    = lapa_q;
  assign disp_tenths   = disp_q.t;
  assign disp_sec_ones = disp_q.so;
  assign disp_sec_tens = disp_q.st;
  assign disp_min_ones = disp_q.mo;
  assign disp_min_tens = disp_q.mt;
  assign wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: elapsed-tenths model plus directed
// vectors with literal display expectations.
module tb_stopwatch_bcd;

  localparam int MTM   = 5;
  localparam int LIMIT = (MTM + 1) * 10 * 600;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_100ms, start_stop, lap_reset;
  logic       timer_enable, running, lap_active, wrap_pulse;
  logic [3:0] disp_tenths, disp_sec_ones, disp_sec_tens;
  logic [3:0] disp_min_ones, disp_min_tens;

  int checks   = 0;
  int failures = 0;

  stopwatch_bcd #(.MIN_TENS_MAX(MTM)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_100ms   (tick_100ms),
    .start_stop   (start_stop),
    .lap_reset    (lap_reset),
    .timer_enable (timer_enable),
    .running      (running),
    .lap_active   (lap_active),
    .disp_tenths  (disp_tenths),
    .disp_sec_ones(disp_sec_ones),
    .disp_sec_tens(disp_sec_tens),
    .disp_min_ones(disp_min_ones),
    .disp_min_tens(disp_min_tens),
    .wrap_pulse   (wrap_pulse)
  );

  always #5 clk = ~clk;

  // Model: elapsed time as a plain count of tenths
  int m_cnt, m_lapv;
  bit m_run, m_lap, m_wrap;

  function automatic logic [19:0] to_bcd(input int n);
    int m, s;
    m = n / 600;
    s = (n / 10) % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10),
            4'(s % 10), 4'(n % 10)};
  endfunction

  always @(posedge clk or negedge rst) begin
    int pre;
    if (!rst) begin
      m_cnt = 0; m_lapv = 0;
      m_run = 0; m_lap = 0; m_wrap = 0;
    end else begin
      pre    = m_cnt;
      m_wrap = 0;
      if (m_run && tick_100ms) begin
        m_wrap = (m_cnt == LIMIT - 1);
        m_cnt  = (m_cnt + 1) % LIMIT;
      end
      if (start_stop) begin
        m_lap = 0;
        m_run = !m_run;
      end else if (lap_reset) begin
        if (m_run) begin
          if (!m_lap) m_lapv = pre;
          m_lap = !m_lap;
        end else begin
          m_cnt  = 0;
          m_lapv = 0;
        end
      end
    end
  end

  wire [19:0] dut_disp = {disp_min_tens, disp_min_ones,
                          disp_sec_tens, disp_sec_ones,
                          disp_tenths};
  wire [23:0] dut_all = {timer_enable, running, lap_active,
                         wrap_pulse, dut_disp};

  always @(negedge clk) begin
    logic [23:0] exp;
    if (rst) begin
      exp = {m_run, m_run, m_lap, m_wrap,
             m_lap ? to_bcd(m_lapv) : to_bcd(m_cnt)};
      checks++;
      if (dut_all !== exp) begin
        failures++;
        $display("FAIL model_cycle t=%0t got=%h exp=%h",
                 $time, dut_all, exp);
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_disp(input string nm, input int mt,
                          input int mo, input int st,
                          input int so, input int t);
    chk(nm, 32'(dut_disp),
        32'({4'(mt), 4'(mo), 4'(st), 4'(so), 4'(t)}));
  endtask

  task automatic cyc(input logic tk, input logic ss,
                     input logic lr);
    tick_100ms = tk; start_stop = ss; lap_reset = lr;
    @(posedge clk);
    #1;
    tick_100ms = 0; start_stop = 0; lap_reset = 0;
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0);
  endtask

  initial begin
    rst = 0; tick_100ms = 0; start_stop = 0; lap_reset = 0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1;
    chk("reset_flags",
        {timer_enable, running, lap_active, wrap_pulse}, 0);
    chk_disp("reset_disp", 0, 0, 0, 0, 0);

    cyc(0, 1, 0);
    chk("start_enable", {timer_enable, running}, 2'b11);
    ticks(25);
    chk_disp("disp_02_5", 0, 0, 0, 2, 5);

    ticks(74);
    chk_disp("disp_09_9", 0, 0, 0, 9, 9);
    ticks(1);
    chk_disp("carry_10_0", 0, 0, 1, 0, 0);
    ticks(499);
    chk_disp("disp_59_9", 0, 0, 5, 9, 9);
    ticks(1);
    chk_disp("carry_01_00_0", 0, 1, 0, 0, 0);

    cyc(0, 1, 0);
    chk("pause_enable", {timer_enable, running}, 2'b00);
    ticks(5);
    chk_disp("pause_hold", 0, 1, 0, 0, 0);
    cyc(0, 0, 1);
    chk_disp("clear_idle", 0, 0, 0, 0, 0);
    cyc(0, 0, 1);
    chk_disp("idle_lr_ignored", 0, 0, 0, 0, 0);
    ticks(3);
    chk("idle_ticks_ignored", 32'(dut_disp), 0);

    cyc(0, 1, 0);
    ticks(34);
    chk_disp("pre_lap_03_4", 0, 0, 0, 3, 4);
    cyc(1, 0, 1);
    chk_disp("lap_freeze", 0, 0, 0, 3, 4);
    chk("lap_active", lap_active, 1);
    ticks(10);
    chk_disp("lap_still", 0, 0, 0, 3, 4);
    cyc(0, 0, 1);
    chk_disp("lap_release", 0, 0, 0, 4, 5);
    chk("lap_off", {lap_active, running}, 2'b01);

    cyc(0, 1, 1);
    chk("both_cmds", {running, lap_active, timer_enable}, 0);
    chk_disp("both_hold", 0, 0, 0, 4, 5);
    cyc(0, 0, 1);

    cyc(0, 1, 0);
    ticks(LIMIT - 1);
    chk_disp("max_59_59_9", 5, 9, 5, 9, 9);
    chk("no_wrap_yet", wrap_pulse, 0);
    ticks(1);
    chk_disp("wrap_zero", 0, 0, 0, 0, 0);
    chk("wrap_high", wrap_pulse, 1);
    ticks(1);
    chk("wrap_once", wrap_pulse, 0);
    chk_disp("after_wrap", 0, 0, 0, 0, 1);

    cyc(1, 1, 0);
    chk_disp("tick_on_stop", 0, 0, 0, 0, 2);
    chk("stopped", running, 0);

    cyc(0, 1, 0);
    ticks(7);
    cyc(0, 0, 1);
    ticks(4);
    chk("in_lap", lap_active, 1);
    #2;
    rst = 0;
    #1;
    chk("rst_flags",
        {timer_enable, running, lap_active, wrap_pulse}, 0);
    chk_disp("rst_disp", 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst = 1;
    cyc(0, 0, 1);
    chk("post_rst_idle", {running, lap_active}, 0);
    cyc(0, 1, 0);
    ticks(2);
    chk_disp("post_rst_count", 0, 0, 0, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Stopwatch control and BCD time-keeping stage, directly downstream of the 100 ms timebase. It drives the timebase `enable` and consumes its single-cycle 100 ms tick. It accumulates elapsed time as MM:SS.t in BCD with start/stop and lap/reset controls, and presents either live or lap-frozen digits to the display logic.

## Interface
- `MIN_TENS_MAX`, default 5: upper value of the minutes-tens digit. The count wraps after `MIN_TENS_MAX`9:59.9.
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `tick_100ms`  in  1  single-cycle pulse from the 100 ms timebase.
- `start_stop`  in  1  single-cycle, debounced command pulse.
- `lap_reset`  in  1  single-cycle, debounced command pulse.
- `timer_enable`  out  1  drives the timebase `enable`; high in RUNNING and LAP.
- `running`  out  1  high in RUNNING and LAP.
- `lap_active`  out  1  high in LAP only.
- `disp_tenths`  out  4  displayed tenths digit, 0-9.
- `disp_sec_ones`  out  4  displayed seconds-ones digit, 0-9.
- `disp_sec_tens`  out  4  displayed seconds-tens digit, 0-5.
- `disp_min_ones`  out  4  displayed minutes-ones digit, 0-9.
- `disp_min_tens`  out  4  displayed minutes-tens digit, 0 to `MIN_TENS_MAX`.
- `wrap_pulse`  out  1  one-cycle pulse when the count wraps to 00:00.0.

## Operation
- FSM states: IDLE, RUNNING, PAUSED, LAP.
- IDLE: counters hold zero; display is live. `start_stop` goes to RUNNING. `lap_reset` is ignored.
- RUNNING: counts ticks; display is live.
  - `start_stop` goes to PAUSED.
  - `lap_reset` copies the current counter registers into lap registers and goes to LAP.
- LAP: counting continues; display shows the lap registers.
  - `lap_reset` goes to RUNNING with the display live again.
  - `start_stop` goes to PAUSED with the display live; the lap value is discarded.
- PAUSED: counters hold; display is live. `start_stop` goes to RUNNING. `lap_reset` clears all counters and lap registers and goes to IDLE.
- Counting is a BCD cascade: tenths 9→0 carries to sec_ones; sec_ones 9→0 carries to sec_tens; sec_tens 5→0 carries to min_ones; min_ones 9→0 carries to min_tens.
- At `MIN_TENS_MAX`9:59.9, a tick sets all digits to 0 and asserts `wrap_pulse`. Counting continues after the wrap.
- A tick is counted only if the current state is RUNNING or LAP. Ticks in IDLE or PAUSED are ignored.
- Simultaneous events:
  - `start_stop` and `lap_reset` in the same cycle: `start_stop` wins and `lap_reset` is dropped.
  - Tick in the same cycle as a command: the tick is evaluated against the current state, so a tick coinciding with stop is still counted.
  - Lap capture coinciding with a tick captures the pre-increment value. The live counters still increment.
- When `timer_enable` falls, the timebase discards its partial 1-99 ms fraction. This loss of up to 99.9 ms per pause is accepted behaviour.
- Asserting `rst` at any time, including mid-count or in LAP, immediately returns the block to IDLE with everything zeroed.

## Timing
- All outputs are registered.
- Reset values: state IDLE, all digits 0, lap registers 0, `timer_enable`=0, `running`=0, `lap_active`=0, `wrap_pulse`=0.
- Command latency: a command sampled at edge N changes state, `timer_enable`, `running`, `lap_active` and the display source, all visible after edge N.
- Tick latency: a tick sampled at edge N updates the digits, visible after edge N (1 cycle).
- `wrap_pulse` is high for exactly the one cycle following the wrapping edge.
- Back-to-back ticks on consecutive cycles must each be counted (no tick spacing is assumed).
- Commands on consecutive cycles are each processed; there is no lockout.
- `rst` deassertion is synchronous to `clk` at system level; the first tick or command is accepted on the first edge after release.

## Test plan
- Reset, then `start_stop`, then 25 ticks: `timer_enable`=1 one cycle after the command, and the display reads 00:02.5.
- RUNNING at 00:09.9 with a tick: display reads 00:10.0. At 00:59.9 with a tick: display reads 01:00.0.
- At 59:59.9 with one tick: display reads 00:00.0, `wrap_pulse` is high for exactly one cycle, and the count continues to 00:00.1 on the next tick.
- RUNNING at 00:03.4, `lap_reset` asserted in the same cycle as a tick:
  - the display freezes at 00:03.4 and `lap_active`=1;
  - after 10 more ticks the display is still 00:03.4;
  - then `lap_reset`: the display shows 00:04.5.
- From RUNNING, `start_stop`: PAUSED and `timer_enable`=0. Then 5 ticks: digits unchanged. Then `lap_reset`: IDLE, display 00:00.0.
- `start_stop` and `lap_reset` in the same cycle from RUNNING: state is PAUSED and `lap_active` stays 0.
- `rst` asserted mid-LAP: all outputs are at reset values immediately, before the next clock edge.
